// File: rtl/spi_seq_pkg.sv
// Shared state encoding, default geometry and counter-width helper for the
// SPI select sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_STRINGS     = 18;
  localparam int DEF_NUM_BOARDS      = 2;
  localparam int DEF_BITS_PER_STRING = 24;
  localparam int DEF_GAP_CYCLES      = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level followed by registered
// rising/falling edge pulses (input edge -> pulse is 3 clk).
module sync_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [2:0] vld_q, vld_d;

  // vld_q tracks when prev_q first holds a real sample, so the reset value
  // never produces a phantom edge against an input already at the other level.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
    vld_d  = {vld_q[1:0], 1'b1};
    rise_d = vld_q[2] &  s2_q & ~prev_q;
    fall_d = vld_q[2] & ~s2_q &  prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      vld_q  <= 3'b000;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      vld_q  <= vld_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_select_sequencer.sv
// Walks a one-hot string/board select across a frame by counting MCU SCK
// rising edges, with an all-low settle gap between strings.
module spi_select_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_STRINGS     = DEF_NUM_STRINGS,
  parameter int NUM_BOARDS      = DEF_NUM_BOARDS,
  parameter int BITS_PER_STRING = DEF_BITS_PER_STRING,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sck_in,
  input  logic                   frame_n,
  output logic [NUM_BOARDS-1:0]  bd_act,
  output logic [NUM_STRINGS-1:0] s_act,
  output logic                   frame_done,
  output logic                   abort,
  output logic                   err_gap
);

  localparam int BIT_W = cnt_width(BITS_PER_STRING);
  localparam int STR_W = cnt_width(NUM_STRINGS);
  localparam int BD_W  = cnt_width(NUM_BOARDS);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_STRING - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(NUM_STRINGS - 1);
  localparam logic [BD_W-1:0]  BD_LAST  = BD_W'(NUM_BOARDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic sck_rise, sck_fall_unused;
  logic frame_rise, frame_fall;

  // Only SCK rising edges shift data; falling edges carry no meaning here.
  sync_edge_det #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck_in),
    .rise (sck_rise),
    .fall (sck_fall_unused)
  );

  sync_edge_det #(.RESET_VAL(1'b1)) u_frame_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (frame_n),
    .rise (frame_rise),
    .fall (frame_fall)
  );

  seq_state_e             state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [STR_W-1:0]       str_q, str_d;
  logic [BD_W-1:0]        bd_q, bd_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [NUM_BOARDS-1:0]  bd_act_q, bd_act_d;
  logic [NUM_STRINGS-1:0] s_act_q, s_act_d;
  logic                   frame_done_q, frame_done_d;
  logic                   abort_q, abort_d;
  logic                   err_gap_q, err_gap_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    str_d        = str_q;
    bd_d         = bd_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    err_gap_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          str_d     = '0;
          bd_d      = '0;
        end
      end
      SHIFT: begin
        if (frame_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (sck_rise) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = GAP;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (frame_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          // A stray edge here is flagged but neither counted nor allowed to stretch the gap.
          err_gap_d = sck_rise;
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (str_q != STR_LAST) begin
              str_d   = str_q + 1'b1;
              state_d = SHIFT;
            end else if (bd_q != BD_LAST) begin
              str_d   = '0;
              bd_d    = bd_q + 1'b1;
              state_d = SHIFT;
            end else begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      bit_cnt_d = '0;
      str_d     = '0;
      bd_d      = '0;
      gap_cnt_d = '0;
    end

    // Selects are decoded from next state so they register alongside the FSM.
    for (int k = 0; k < NUM_STRINGS; k++) begin
      s_act_d[k] = (state_d == SHIFT) && (str_d == STR_W'(k));
    end
    for (int k = 0; k < NUM_BOARDS; k++) begin
      bd_act_d[k] = (state_d == SHIFT) && (bd_d == BD_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      str_q        <= '0;
      bd_q         <= '0;
      gap_cnt_q    <= '0;
      bd_act_q     <= '0;
      s_act_q      <= '0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      err_gap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      str_q        <= str_d;
      bd_q         <= bd_d;
      gap_cnt_q    <= gap_cnt_d;
      bd_act_q     <= bd_act_d;
      s_act_q      <= s_act_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      err_gap_q    <= err_gap_d;
    end
  end

  assign bd_act     = bd_act_q;
  assign s_act      = s_act_q;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;
  assign err_gap    = err_gap_q;

endmodule

// File: tb/tb_spi_select_sequencer.sv
// Directed-sequence bench with randomized SCK timing for the SPI select
// sequencer; expectations come from frame position (string, board) arithmetic.
module tb_spi_select_sequencer;

  localparam int NS  = 18;
  localparam int NB  = 2;
  localparam int BPS = 24;
  localparam int G   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sck, frame_n;
  logic [NB-1:0] bd_act;
  logic [NS-1:0] s_act;
  logic          frame_done, abort, err_gap;

  logic          sck2, frame2_n;
  logic [0:0]    bd_act2;
  logic [2:0]    s_act2;
  logic          frame_done2, abort2, err_gap2;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int fd_cnt = 0, ab_cnt = 0, eg_cnt = 0;
  int fd2_cnt = 0, ab2_cnt = 0, eg2_cnt = 0;

  always #5 clk = ~clk;

  spi_select_sequencer #(
    .NUM_STRINGS(NS), .NUM_BOARDS(NB), .BITS_PER_STRING(BPS), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sck_in(sck), .frame_n(frame_n),
    .bd_act(bd_act), .s_act(s_act), .frame_done(frame_done),
    .abort(abort), .err_gap(err_gap)
  );

  spi_select_sequencer #(
    .NUM_STRINGS(3), .NUM_BOARDS(1), .BITS_PER_STRING(2), .GAP_CYCLES(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .sck_in(sck2), .frame_n(frame2_n),
    .bd_act(bd_act2), .s_act(s_act2), .frame_done(frame_done2),
    .abort(abort2), .err_gap(err_gap2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every wait goes through here: one-hot invariant and pulse tallies each cycle.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_total++;
      assert ($onehot0(s_act) && $onehot0(bd_act) && ((s_act != 0) == (bd_act != 0)) &&
              $onehot0(s_act2) && ((s_act2 != 0) == (bd_act2 != 0))) n_pass++;
      else begin
        n_fail++;
        $error("FAIL onehot observed s_act=%0h bd_act=%0h s_act2=%0h bd_act2=%0h expected at most one bit per field, both or neither",
               s_act, bd_act, s_act2, bd_act2);
      end
      if (frame_done)  fd_cnt++;
      if (abort)       ab_cnt++;
      if (err_gap)     eg_cnt++;
      if (frame_done2) fd2_cnt++;
      if (abort2)      ab2_cnt++;
      if (err_gap2)    eg2_cnt++;
    end
  endtask

  function automatic logic [31:0] act_obs();
    return 32'({bd_act, s_act});
  endfunction

  function automatic logic [31:0] out_obs();
    return 32'({frame_done, abort, err_gap, bd_act, s_act});
  endfunction

  function automatic logic [31:0] exp_act(input int str, input int bd);
    logic [31:0] r;
    r = 32'(1) << str;
    r = r | (32'(1) << (NS + bd));
    return r;
  endfunction

  task automatic sck_pulse();
    sck = 1'b1;
    tick($urandom_range(3, 5));
    sck = 1'b0;
    tick($urandom_range(3, 5));
  endtask

  task automatic start_frame();
    frame_n = 1'b1;
    tick(4);
    frame_n = 1'b0;
    tick(3);
    check("frame_start_t3", act_obs(), 32'd0);
    tick(1);
    check("frame_start_t4", act_obs(), exp_act(0, 0));
  endtask

  // Shift one whole string; t is the cycle the last SCK rise is driven.
  task automatic run_string(input int str, input int bd, input bit extra, input bit last);
    int eg_before, nstr, nbd;
    eg_before = eg_cnt;
    nstr = (str < NS - 1) ? str + 1 : 0;
    nbd  = (str < NS - 1) ? bd : bd + 1;
    tick($urandom_range(1, 3));
    for (int b = 0; b < BPS - 1; b++) begin
      sck_pulse();
      check("act_shift", act_obs(), exp_act(str, bd));
    end
    sck = 1'b1;
    if (extra) begin
      tick(1);
      sck = 1'b0;
      tick(2);
      sck = 1'b1;
      check("act_last_t3", act_obs(), exp_act(str, bd));
      tick(1);
      check("act_drop_t4", act_obs(), 32'd0);
      tick(2);
      sck = 1'b0;
    end else begin
      tick(3);
      check("act_last_t3", act_obs(), exp_act(str, bd));
      tick(1);
      check("act_drop_t4", act_obs(), 32'd0);
      sck = 1'b0;
      tick(2);
    end
    tick(1);
    check("act_gap_t7", act_obs(), 32'd0);
    check("err_gap_count", 32'(eg_cnt), 32'(eg_before + (extra ? 1 : 0)));
    tick(1);
    if (last) begin
      check("act_after_frame", act_obs(), 32'd0);
      check("frame_done_pulse", 32'(frame_done), 32'd1);
    end else begin
      check("act_next_string", act_obs(), exp_act(nstr, nbd));
    end
  endtask

  initial begin
    int fd_b, ab_b, eg_b;
    rst_n = 1'b0; sck = 1'b0; frame_n = 1'b0; sck2 = 1'b0; frame2_n = 1'b1;

    // Reset with frame held low and SCK toggling
    tick(2);
    check("reset_outputs", out_obs(), 32'd0);
    sck = 1'b1; tick(3); sck = 1'b0; tick(3);
    check("reset_sck_toggle", out_obs(), 32'd0);
    rst_n = 1'b1;
    repeat (4) sck_pulse();
    check("no_start_without_fresh_fall", out_obs(), 32'd0);
    check("no_abort_after_reset", 32'(ab_cnt), 32'd0);

    // Async reset mid-frame, then a fresh fall is required
    start_frame();
    repeat (5) sck_pulse();
    check("mid_frame_act", act_obs(), exp_act(0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", out_obs(), 32'd0);
    tick(2);
    rst_n = 1'b1;
    repeat (3) sck_pulse();
    check("no_restart_after_reset", out_obs(), 32'd0);

    // Frame A: stray gap edge after string 5, abort in string 10 at bit 7
    start_frame();
    for (int s = 0; s < 10; s++) run_string(s, 0, (s == 5), 1'b0);
    repeat (7) sck_pulse();
    check("abort_pre_act", act_obs(), exp_act(10, 0));
    ab_b = ab_cnt;
    frame_n = 1'b1;
    tick(3);
    check("abort_t3_act", act_obs(), exp_act(10, 0));
    check("abort_t3_pulse", 32'(abort), 32'd0);
    tick(1);
    check("abort_t4_act", act_obs(), 32'd0);
    check("abort_t4_pulse", 32'(abort), 32'd1);
    tick(1);
    check("abort_single_pulse", 32'(ab_cnt), 32'(ab_b + 1));
    check("abort_no_frame_done", 32'(fd_cnt), 32'd0);

    // Frame B: full frame across both board groups
    start_frame();
    fd_b = fd_cnt; eg_b = eg_cnt; ab_b = ab_cnt;
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++)
        run_string(s, b, 1'b0, (b == NB - 1) && (s == NS - 1));
    tick(1);
    check("frame_done_once", 32'(fd_cnt), 32'(fd_b + 1));
    check("frame_no_err_gap", 32'(eg_cnt), 32'(eg_b));
    check("idle_outputs", out_obs(), 32'd0);
    frame_n = 1'b1;
    repeat (3) sck_pulse();
    check("idle_no_abort", 32'(ab_cnt), 32'(ab_b));
    check("idle_sck_ignored", out_obs(), 32'd0);

    // SCK rise coincident with frame_n rise: abort wins
    start_frame();
    repeat (BPS - 1) sck_pulse();
    eg_b = eg_cnt; fd_b = fd_cnt;
    sck = 1'b1;
    frame_n = 1'b1;
    tick(3);
    check("coincident_t3_act", act_obs(), exp_act(0, 0));
    tick(1);
    check("coincident_abort", 32'(abort), 32'd1);
    check("coincident_act", act_obs(), 32'd0);
    sck = 1'b0;
    tick(8);
    check("coincident_no_err", 32'(eg_cnt), 32'(eg_b));
    check("coincident_no_done", 32'(fd_cnt), 32'(fd_b));
    check("coincident_idle", out_obs(), 32'd0);

    // Small instance: 3 strings x 2 bits, one board, 1-cycle gap
    frame2_n = 1'b0;
    tick(4);
    for (int n = 0; n < 6; n++) begin
      check("small_pre_rise", 32'({bd_act2, s_act2}), 32'({1'b1, 3'(1 << (n / 2))}));
      sck2 = 1'b1;
      tick(4);
      check("small_post_rise", 32'({bd_act2, s_act2}),
            (n % 2 == 1) ? 32'd0 : 32'({1'b1, 3'(1 << (n / 2))}));
      sck2 = 1'b0;
      tick(4);
    end
    check("small_frame_done", 32'(fd2_cnt), 32'd1);
    check("small_idle", 32'({frame_done2, abort2, err_gap2, bd_act2, s_act2}), 32'd0);
    check("small_no_err_abort", 32'(eg2_cnt + ab2_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
